// File: rtl/xdma_narrow_to_remote_arb_if.sv
// Bundle of the narrow requester ports and the single-beat AXI AW/W/B channels
// served by xdma_narrow_to_remote_arb.
interface xdma_narrow_to_remote_arb_if #(
  parameter int unsigned NumInp    = 3,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 48
);
  logic [NumInp-1:0]           req_valid_i;
  logic [NumInp-1:0]           req_ready_o;
  logic [NumInp*AddrWidth-1:0] req_addr_i;
  logic [NumInp*DataWidth-1:0] req_data_i;
  logic                        aw_valid_o;
  logic                        aw_ready_i;
  logic [AddrWidth-1:0]        aw_addr_o;
  logic [1:0]                  aw_id_o;
  logic                        w_valid_o;
  logic                        w_ready_i;
  logic [DataWidth-1:0]        w_data_o;
  logic [DataWidth/8-1:0]      w_strb_o;
  logic                        w_last_o;
  logic                        b_valid_i;
  logic                        b_ready_o;
  logic [1:0]                  b_resp_i;
  logic                        busy_o;
  logic                        err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
    output req_ready_o, aw_valid_o, aw_addr_o, aw_id_o, w_valid_o, w_data_o, w_strb_o,
           w_last_o, b_ready_o, busy_o, err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
    input  req_ready_o, aw_valid_o, aw_addr_o, aw_id_o, w_valid_o, w_data_o, w_strb_o,
           w_last_o, b_ready_o, busy_o, err_o
  );
endinterface

// File: rtl/xdma_narrow_to_remote_arb.sv
// Round-robin arbiter funnelling narrow single-beat requests into one AXI write
// (AW+W, then B); one transfer in flight at a time.
module xdma_narrow_to_remote_arb #(
  parameter int unsigned NumInp    = 3,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 48
) (
  input logic                         clk_i,
  input logic                         rst_i,
  xdma_narrow_to_remote_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_e;

  state_e               state_q, state_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [1:0]           id_q, id_d;
  logic                 aw_valid_q, aw_valid_d;
  logic                 w_valid_q, w_valid_d;
  logic                 b_ready_q, b_ready_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 grant_vld;
  logic [1:0]           grant_idx;
  int unsigned          cand;
  logic [NumInp-1:0]    req_ready;
  logic                 aw_hs, w_hs;

  // Round-robin search begins just after the previous winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NumInp; k++) begin
      cand = (32'(last_grant_q) + k) % NumInp;
      if (!grant_vld && bus.req_valid_i[cand[1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[1:0];
      end
    end
  end

  // Accept is combinational so the requester sees it in the grant cycle itself.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_vld && !rst_i) req_ready[grant_idx] = 1'b1;
  end

  assign aw_hs = aw_valid_q & bus.aw_ready_i;
  assign w_hs  = w_valid_q & bus.w_ready_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    addr_d       = addr_q;
    data_d       = data_q;
    id_d         = id_q;
    aw_valid_d   = aw_valid_q;
    w_valid_d    = w_valid_q;
    b_ready_d    = b_ready_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          addr_d       = bus.req_addr_i[32'(grant_idx)*AddrWidth +: AddrWidth];
          data_d       = bus.req_data_i[32'(grant_idx)*DataWidth +: DataWidth];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          aw_valid_d   = 1'b1;
          w_valid_d    = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        aw_done_d  = aw_done_q | aw_hs;
        w_done_d   = w_done_q | w_hs;
        aw_valid_d = aw_valid_q & ~aw_hs;
        w_valid_d  = w_valid_q & ~w_hs;
        if (aw_done_d && w_done_d) begin
          b_ready_d = 1'b1;
          state_d   = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.b_valid_i) begin
          b_ready_d = 1'b0;
          err_d     = (bus.b_resp_i != 2'b00);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 2'(NumInp - 1);
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      id_q         <= '0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      id_q         <= id_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      b_ready_q    <= b_ready_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.aw_valid_o  = aw_valid_q;
  assign bus.aw_addr_o   = addr_q;
  assign bus.aw_id_o     = id_q;
  assign bus.w_valid_o   = w_valid_q;
  assign bus.w_data_o    = data_q;
  assign bus.w_strb_o    = '1;
  assign bus.w_last_o    = 1'b1;
  assign bus.b_ready_o   = b_ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_xdma_narrow_to_remote_arb.sv
// Self-checking bench for xdma_narrow_to_remote_arb: scripted vector table,
// hand-written ordering/reset sequences and a randomized run against a
// transaction-level reference model.
module tb_xdma_narrow_to_remote_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xdma_narrow_to_remote_arb_if #(.NumInp(3), .DataWidth(64), .AddrWidth(48)) bus ();

  xdma_narrow_to_remote_arb #(.NumInp(3), .DataWidth(64), .AddrWidth(48)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [47:0] paddr [3];
  logic [63:0] pdata [3];

  typedef struct {
    logic [2:0] rv;
    logic       ar, wr, bv;
    logic [1:0] br;
    logic [2:0] rr;
    logic       aw, w, b, busy, err;
    logic [1:0] id;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [2:0] rv, input logic ar, input logic wr,
                              input logic bv, input logic [1:0] br, input logic [2:0] rr,
                              input logic aw, input logic w, input logic b,
                              input logic busy, input logic err, input logic [1:0] id);
    vec_t v;
    v.rv = rv; v.ar = ar; v.wr = wr; v.bv = bv; v.br = br;
    v.rr = rr; v.aw = aw; v.w = w; v.b = b; v.busy = busy; v.err = err; v.id = id;
    return v;
  endfunction

  task automatic drive(input logic [2:0] rv, input logic ar, input logic wr,
                       input logic bv, input logic [1:0] br);
    bus.req_valid_i = rv;
    bus.aw_ready_i  = ar;
    bus.w_ready_i   = wr;
    bus.b_valid_i   = bv;
    bus.b_resp_i    = br;
    bus.req_addr_i  = {paddr[2], paddr[1], paddr[0]};
    bus.req_data_i  = {pdata[2], pdata[1], pdata[0]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctl_vec();
    return {bus.req_ready_o, bus.aw_valid_o, bus.w_valid_o, bus.b_ready_o, bus.busy_o, bus.err_o};
  endfunction

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int rr_pick(input logic [2:0] v, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (v[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  // Reference model state: one transaction in flight with its pending channels.
  bit          m_inflight, m_awp, m_wp, m_err;
  int          m_last;
  logic [1:0]  m_id;
  logic [47:0] m_addr;
  logic [63:0] m_data;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          gcyc [$];
    int          gidx [$];
    int          g;
    logic [2:0]  rv, exp_rr;
    logic [7:0]  exp_ctl;

    paddr[0] = 48'h0A00; pdata[0] = 64'h1111_1111_1111_1111;
    paddr[1] = 48'h0B00; pdata[1] = 64'h2222_2222_2222_2222;
    paddr[2] = 48'h1000; pdata[2] = 64'hDEAD_BEEF;

    //                rv     ar    wr    bv    br      rr     aw    w     b     busy  err   id
    tbl[0]  = mk(3'b100,1'b1,1'b1,1'b0,2'b00, 3'b100,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0);
    tbl[1]  = mk(3'b000,1'b1,1'b1,1'b0,2'b00, 3'b000,1'b1,1'b1,1'b0,1'b1,1'b0,2'd2);
    tbl[2]  = mk(3'b000,1'b1,1'b1,1'b1,2'b00, 3'b000,1'b0,1'b0,1'b1,1'b1,1'b0,2'd2);
    tbl[3]  = mk(3'b000,1'b1,1'b1,1'b1,2'b10, 3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0);
    tbl[4]  = mk(3'b001,1'b0,1'b0,1'b1,2'b10, 3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0);
    tbl[5]  = mk(3'b000,1'b1,1'b0,1'b0,2'b00, 3'b000,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0);
    tbl[6]  = mk(3'b000,1'b0,1'b0,1'b0,2'b00, 3'b000,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0);
    tbl[7]  = mk(3'b000,1'b0,1'b0,1'b0,2'b00, 3'b000,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0);
    tbl[8]  = mk(3'b000,1'b0,1'b1,1'b0,2'b00, 3'b000,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0);
    tbl[9]  = mk(3'b000,1'b0,1'b0,1'b1,2'b10, 3'b000,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0);
    tbl[10] = mk(3'b000,1'b0,1'b0,1'b0,2'b00, 3'b000,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0);
    tbl[11] = mk(3'b000,1'b0,1'b0,1'b0,2'b00, 3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0);
    tbl[12] = mk(3'b010,1'b0,1'b0,1'b0,2'b00, 3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0);
    tbl[13] = mk(3'b000,1'b0,1'b1,1'b0,2'b00, 3'b000,1'b1,1'b1,1'b0,1'b1,1'b0,2'd1);
    tbl[14] = mk(3'b000,1'b0,1'b0,1'b0,2'b00, 3'b000,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1);
    tbl[15] = mk(3'b000,1'b0,1'b0,1'b0,2'b00, 3'b000,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1);
    tbl[16] = mk(3'b000,1'b1,1'b0,1'b0,2'b00, 3'b000,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1);
    tbl[17] = mk(3'b000,1'b0,1'b0,1'b1,2'b00, 3'b000,1'b0,1'b0,1'b1,1'b1,1'b0,2'd1);
    tbl[18] = mk(3'b000,1'b0,1'b0,1'b0,2'b00, 3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0);

    // Reset state
    drive(3'b000, 1'b0, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;
    #3;
    check("reset_ctl", 128'(ctl_vec()), 128'(8'h00));
    check("reset_strb_last", 128'({bus.w_strb_o, bus.w_last_o}), 128'({8'hFF, 1'b1}));
    check("reset_payload", 128'({bus.aw_id_o, bus.aw_addr_o, bus.w_data_o}), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Table of single, error, and split-handshake transfers
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rv, tbl[i].ar, tbl[i].wr, tbl[i].bv, tbl[i].br);
      #4;
      check($sformatf("vec%0d_ctl", i), 128'(ctl_vec()),
            128'({tbl[i].rr, tbl[i].aw, tbl[i].w, tbl[i].b, tbl[i].busy, tbl[i].err}));
      if (tbl[i].aw || tbl[i].w)
        check($sformatf("vec%0d_payload", i),
              128'({bus.aw_id_o, bus.aw_addr_o, bus.w_data_o}),
              128'({tbl[i].id, paddr[tbl[i].id], pdata[tbl[i].id]}));
      @(posedge clk);
      #1;
    end

    // All requesters valid, immediate ready and B: order 0,1,2,0 every 3 cycles
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(3'b111, 1'b1, 1'b1, 1'b1, 2'b00);
      #4;
      if (bus.req_ready_o != 3'b000) begin
        gcyc.push_back(c);
        gidx.push_back(bus.req_ready_o == 3'b001 ? 0 : bus.req_ready_o == 3'b010 ? 1 :
                       bus.req_ready_o == 3'b100 ? 2 : 9);
      end
      @(posedge clk);
      #1;
    end
    check("rr_grant_count", 128'(gcyc.size()), 128'(4));
    for (int k = 0; k < 4 && k < gcyc.size(); k++) begin
      check($sformatf("rr_grant%0d_idx", k), 128'(gidx[k]), 128'(k % 3));
      check($sformatf("rr_grant%0d_cycle", k), 128'(gcyc[k]), 128'(3 * k));
    end

    // Reset asserted mid-SEND abandons the transfer
    do_reset();
    drive(3'b111, 1'b0, 1'b0, 1'b0, 2'b00);
    @(posedge clk);
    #4;
    check("midsend_aw_valid", 128'({bus.aw_valid_o, bus.busy_o}), 128'(2'b11));
    #1 rst = 1'b1;
    #1;
    check("midsend_reset_ctl", 128'(ctl_vec()), 128'(8'h00));
    @(posedge clk);
    #1 rst = 1'b0;
    #3;
    check("post_reset_first_grant", 128'(bus.req_ready_o), 128'(3'b001));
    @(posedge clk);
    #1;
    drive(3'b000, 1'b1, 1'b1, 1'b1, 2'b00);
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic against the transaction-level model
    do_reset();
    m_inflight = 0; m_awp = 0; m_wp = 0; m_err = 0; m_last = 2;
    m_id = '0; m_addr = '0; m_data = '0;
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < 3; r++) begin
        paddr[r] = {16'($urandom), 32'($urandom)};
        pdata[r] = {32'($urandom), 32'($urandom)};
      end
      rv = 3'($urandom);
      drive(rv, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3) == 0 ? $urandom : 0));
      #4;
      g = m_inflight ? -1 : rr_pick(rv, m_last);
      exp_rr = (g >= 0) ? 3'(1 << g) : 3'b000;
      exp_ctl = {exp_rr, m_inflight && m_awp, m_inflight && m_wp,
                 m_inflight && !m_awp && !m_wp, m_inflight, m_err};
      check($sformatf("rand%0d_ctl", c), 128'(ctl_vec()), 128'(exp_ctl));
      if (m_inflight)
        check($sformatf("rand%0d_payload", c),
              128'({bus.aw_id_o, bus.aw_addr_o, bus.w_data_o}),
              128'({m_id, m_addr, m_data}));
      m_err = 0;
      if (!m_inflight) begin
        if (g >= 0) begin
          m_inflight = 1; m_awp = 1; m_wp = 1; m_last = g;
          m_id = 2'(g); m_addr = paddr[g]; m_data = pdata[g];
        end
      end else if (m_awp || m_wp) begin
        if (bus.aw_ready_i) m_awp = 0;
        if (bus.w_ready_i)  m_wp  = 0;
      end else if (bus.b_valid_i) begin
        m_inflight = 0;
        m_err = (bus.b_resp_i != 2'b00);
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xdma_narrow_to_remote_arb.md
XDMA_NARROW_TO_REMOTE_ARB -- requirements
Module: xdma_narrow_to_remote_arb

Interface
REQ-001 SHALL have parameter NumInp, default 3, number of narrow requesters (index 0 = ToRemoteFinish, 1 = ToRemoteGrant, 2 = ToRemoteCfg).
REQ-002 SHALL have parameter DataWidth, default 64, narrow AXI data width.
REQ-003 SHALL have parameter AddrWidth, default 48, address width.
REQ-004 SHALL have clk_i  in  1  single clock for all logic; rising edge.
REQ-005 SHALL have rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have req_valid_i  in  NumInp  per-requester request valid.
REQ-007 SHALL have req_ready_o  out  NumInp  per-requester accept; at most one bit high.
REQ-008 SHALL have req_addr_i  in  NumInp*AddrWidth  per-requester target address; slice i at [i*AddrWidth +: AddrWidth].
REQ-009 SHALL have req_data_i  in  NumInp*DataWidth  per-requester payload; slice i at [i*DataWidth +: DataWidth].
REQ-010 SHALL have aw_valid_o / aw_ready_i  out / in  1 / 1  AW handshake.
REQ-011 SHALL have aw_addr_o  out  AddrWidth  latched address.
REQ-012 SHALL have aw_id_o  out  2  index of the granted requester.
REQ-013 SHALL have w_valid_o / w_ready_i  out / in  1 / 1  W handshake.
REQ-014 SHALL have w_data_o  out  DataWidth  latched payload.
REQ-015 SHALL have w_strb_o  out  DataWidth/8  all ones.
REQ-016 SHALL have w_last_o  out  1  constant 1; every transfer is a single beat.
REQ-017 SHALL have b_valid_i / b_ready_o / b_resp_i  in / out / in  1 / 1 / 2  B handshake and response.
REQ-018 SHALL have busy_o  out  1  high in any state other than IDLE.
REQ-019 SHALL have err_o  out  1  one-cycle pulse on a non-OKAY B response.

Function
REQ-020 SHALL implement FSM states IDLE, SEND, WAIT_B.
REQ-021 IDLE: when any req_valid_i is high, SHALL grant exactly one requester by round-robin.
- Search starts at (last_grant+1) mod NumInp.
- Assert that requester's req_ready_o combinationally in the same cycle.
REQ-022 On grant, SHALL latch req_addr_i/req_data_i slice and index into registers, update last_grant, and move to SEND at the next edge.
REQ-023 req_ready_o SHALL be all zero in SEND and WAIT_B.
REQ-024 SEND: aw_valid_o and w_valid_o SHALL both assert from the first SEND cycle (one cycle after grant).
- Each SHALL drop independently after its own handshake, tracked by aw_done/w_done flags.
REQ-025 SHALL move from SEND to WAIT_B in the cycle both AW and W have handshaken.
- Covers AW and W completing in the same cycle.
- Covers AW and W completing in either order on different cycles.
REQ-026 While valid, aw_addr_o/w_data_o/aw_id_o SHALL hold stable; valid SHALL NOT drop before ready.
REQ-027 WAIT_B: b_ready_o SHALL be 1 (0 in all other states).
- On b_valid_i, SHALL return to IDLE.
- If b_resp_i != 2'b00, SHALL pulse err_o for exactly the cycle after the handshake.
REQ-028 A new grant SHALL be possible in the first IDLE cycle after B; minimum request-to-request spacing is 3 cycles.
REQ-029 A requester SHALL NOT be granted twice in a row while another requester is valid (no starvation).
REQ-030 req_valid_i deasserting in IDLE before grant SHALL have no effect.
- Valid changes during SEND/WAIT_B SHALL be ignored until IDLE.
REQ-031 aw_ready_i/w_ready_i outside SEND and b_valid_i outside WAIT_B SHALL be ignored.

Reset
REQ-032 SHALL, on rst_i assertion at any time, asynchronously set:
- state = IDLE;
- last_grant = NumInp-1, so index 0 has first priority;
- aw_done = w_done = 0;
- latched address/data/index = 0;
- all outputs = 0 except w_strb_o = all ones and w_last_o = 1.
REQ-033 On reset during SEND or WAIT_B, the in-flight transfer SHALL be abandoned; no err_o and no req_ready_o SHALL be generated for it.

Verification
REQ-034 Bench SHALL run a single request: req_valid_i=3'b100, addr 48'h1000, data 64'hDEAD_BEEF, aw_ready_i=w_ready_i=1.
- Expect req_ready_o=3'b100 at cycle 0.
- Expect aw_valid_o/w_valid_o at cycle 1 with aw_addr_o=48'h1000, w_data_o=64'hDEAD_BEEF, aw_id_o=2.
- Expect b_ready_o at cycle 2.
REQ-035 Bench SHALL hold all three requesters valid with immediate ready/B.
- Expect grant order 0,1,2,0 after reset.
- Expect grants spaced 3 cycles apart.
REQ-036 Bench SHALL drive aw_ready_i 3 cycles before w_ready_i.
- Expect aw_valid_o to drop after its handshake.
- Expect w_valid_o held until its handshake, then WAIT_B.
- Repeat with the ready order reversed.
REQ-037 Bench SHALL return b_resp_i=2'b10.
- Expect a single-cycle err_o pulse, then IDLE.
- Expect no err_o for b_resp_i=2'b00.
REQ-038 Bench SHALL assert rst_i mid-SEND with aw_valid_o=1.
- Expect all valids low immediately and busy_o=0.
- After release with req_valid_i=3'b111, expect the first grant to index 0.
